// File: rtl/playseq_pkg.sv
// rtl/playseq_pkg.sv - shared state codes and defaults for the sequence presenter
//
// Purpose: state encodings (which double as the db_estado display codes),
// default LED on/off durations and the timer width helper.
// Ports: none (package).
package playseq_pkg;

   // State codes are shown directly on the debug 7-seg display.
   typedef enum logic [2:0] {
      OCIOSO = 3'd0,
      BUSCA  = 3'd1,
      ACENDE = 3'd2,
      APAGA  = 3'd3,
      FIM    = 3'd4
   } estado_t;

   localparam int ON_CYCLES_DEF  = 1000;
   localparam int OFF_CYCLES_DEF = 500;

   localparam logic [2:0] DB_OCIOSO = 3'd0;
   localparam logic [2:0] DB_BUSCA  = 3'd1;
   localparam logic [2:0] DB_ACENDE = 3'd2;
   localparam logic [2:0] DB_APAGA  = 3'd3;
   localparam logic [2:0] DB_FIM    = 3'd4;

   // Wide enough to hold the longer of the two phase lengths.
   function automatic int timer_width(input int on_c, input int off_c);
      return $clog2(((on_c > off_c) ? on_c : off_c) + 1);
   endfunction

endpackage

// File: rtl/playseq_temporizador.sv
// rtl/playseq_temporizador.sv - phase timer for the sequence presenter
//
// Purpose: up-counter cleared by i_zera, advanced by i_conta; o_fim flags the
// last cycle of a LIMITE-cycle phase (count == LIMITE-1).
// Ports:
//   i_clock  clock, rising edge
//   i_reset  asynchronous active-low reset
//   i_zera   synchronous clear (wins over i_conta)
//   i_conta  count enable
//   o_fim    high while count == LIMITE-1
module playseq_temporizador #(
   parameter int W      = 2,
   parameter int LIMITE = 3
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_zera,
   input  logic i_conta,
   output logic o_fim
);

   localparam logic [W-1:0] L_ULTIMA = W'(LIMITE - 1);

   logic [W-1:0] r_contagem;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_contagem <= '0;
      end else if (i_zera) begin
         r_contagem <= '0;
      end else if (i_conta) begin
         r_contagem <= r_contagem + 1'b1;
      end
   end

   assign o_fim = (r_contagem == L_ULTIMA);

endmodule

// File: rtl/playseq_mostra_sequencia.sv
// rtl/playseq_mostra_sequencia.sv - plays the stored colour sequence on the LEDs
//
// Purpose: on iniciar, reads RAM words 0..ultimo and shows each for ON_CYCLES
// followed by OFF_CYCLES dark cycles, then pulses pronto for one cycle.
// Optional feature macro: PLAYSEQ_MOSTRA_PAUSA_EN adds the pausar input,
// which freezes timing while showing/darkening a word.
// Ports:
//   clock         clock, rising edge
//   reset         asynchronous active-low reset
//   iniciar       start request (OCIOSO only)
//   abortar       synchronous abort, back to OCIOSO
//   ultimo        index of last word, latched at start
//   ram_dado      RAM read data for ram_endereco
//   pausar        (PLAYSEQ_MOSTRA_PAUSA_EN only) freeze ACENDE/APAGA
//   ram_endereco  RAM read address
//   leds          LED drive
//   ocupado       high outside OCIOSO
//   pronto        one-cycle completion pulse
//   db_estado     state code for debug display
module playseq_mostra_sequencia
   import playseq_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 4,
   parameter int ON_CYCLES  = ON_CYCLES_DEF,
   parameter int OFF_CYCLES = OFF_CYCLES_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   input  logic [ADDR_W-1:0] ultimo,
   input  logic [DATA_W-1:0] ram_dado,
`ifdef PLAYSEQ_MOSTRA_PAUSA_EN
   input  logic              pausar,
`endif
   output logic [ADDR_W-1:0] ram_endereco,
   output logic [DATA_W-1:0] leds,
   output logic              ocupado,
   output logic              pronto,
   output logic [2:0]        db_estado
);

   localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);

   estado_t             r_estado;
   estado_t             w_proximo;
   logic [ADDR_W-1:0]   r_endereco;
   logic [ADDR_W-1:0]   r_ultimo;
   logic [DATA_W-1:0]   r_palavra;
   logic                w_pausa;
   logic                w_fim_on;
   logic                w_fim_off;
   logic                w_zera_on;
   logic                w_zera_off;

`ifdef PLAYSEQ_MOSTRA_PAUSA_EN
   // Pause only matters while a phase timer is running.
   assign w_pausa = pausar && ((r_estado == ACENDE) || (r_estado == APAGA));
`else
   assign w_pausa = 1'b0;
`endif

   // Each timer runs only while its phase continues; any exit (including an
   // abort) clears it so the next entry starts from zero.
   assign w_zera_on  = (r_estado != ACENDE) || (w_proximo != ACENDE);
   assign w_zera_off = (r_estado != APAGA)  || (w_proximo != APAGA);

   playseq_temporizador #(.W(TW), .LIMITE(ON_CYCLES)) u_tempo_on (
      .i_clock (clock),
      .i_reset (reset),
      .i_zera  (w_zera_on),
      .i_conta (!w_zera_on && !w_pausa),
      .o_fim   (w_fim_on)
   );

   playseq_temporizador #(.W(TW), .LIMITE(OFF_CYCLES)) u_tempo_off (
      .i_clock (clock),
      .i_reset (reset),
      .i_zera  (w_zera_off),
      .i_conta (!w_zera_off && !w_pausa),
      .o_fim   (w_fim_off)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_proximo;
      end
   end

   // Next-state logic; abort overrides everything, including a start.
   always_comb begin
      w_proximo = r_estado;
      if (abortar) begin
         w_proximo = OCIOSO;
      end else begin
         case (r_estado)
            OCIOSO: if (iniciar) w_proximo = BUSCA;
            BUSCA:  w_proximo = ACENDE;
            ACENDE: if (w_fim_on && !w_pausa) w_proximo = APAGA;
            APAGA: begin
               if (w_fim_off && !w_pausa) begin
                  w_proximo = (r_endereco == r_ultimo) ? FIM : BUSCA;
               end
            end
            FIM:     w_proximo = OCIOSO;
            default: w_proximo = OCIOSO;
         endcase
      end
   end

   // Datapath: address, latched last index and the LED word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_endereco <= '0;
         r_ultimo   <= '0;
         r_palavra  <= '0;
      end else begin
         if (w_proximo == OCIOSO) begin
            r_endereco <= '0;
         end else if ((r_estado == APAGA) && (w_proximo == BUSCA)) begin
            r_endereco <= r_endereco + 1'b1;
         end
         if ((r_estado == OCIOSO) && (w_proximo == BUSCA)) begin
            r_ultimo <= ultimo;
         end
         if (r_estado == BUSCA) begin
            r_palavra <= ram_dado;
         end
      end
   end

   // Moore outputs
   always_comb begin
      ram_endereco = r_endereco;
      leds         = '0;
      ocupado      = 1'b1;
      pronto       = 1'b0;
      db_estado    = DB_OCIOSO;
      case (r_estado)
         OCIOSO: begin
            ocupado   = 1'b0;
            db_estado = DB_OCIOSO;
         end
         BUSCA:  db_estado = DB_BUSCA;
         ACENDE: begin
            leds      = r_palavra;
            db_estado = DB_ACENDE;
         end
         APAGA:  db_estado = DB_APAGA;
         FIM: begin
            pronto    = 1'b1;
            db_estado = DB_FIM;
         end
         default: begin
            ocupado   = 1'b0;
            db_estado = DB_OCIOSO;
         end
      endcase
   end

endmodule

// File: tb/tb_playseq_mostra_sequencia.sv
// tb/tb_playseq_mostra_sequencia.sv - bench for the sequence presenter
module tb_playseq_mostra_sequencia;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 4;
   localparam int ON     = 3;
   localparam int OFF    = 2;
   localparam int PER    = 1 + ON + OFF;

   logic              clock   = 1'b0;
   logic              reset   = 1'b0;
   logic              iniciar = 1'b0;
   logic              abortar = 1'b0;
   logic [ADDR_W-1:0] ultimo  = '0;
   logic [DATA_W-1:0] ram_dado;
   logic [ADDR_W-1:0] ram_endereco;
   logic [DATA_W-1:0] leds;
   logic              ocupado;
   logic              pronto;
   logic [2:0]        db_estado;
`ifdef PLAYSEQ_MOSTRA_PAUSA_EN
   logic              pausar = 1'b0;
`endif

   logic [DATA_W-1:0] ram [16];
   assign ram_dado = ram[ram_endereco];

   always #5 clock = ~clock;

   playseq_mostra_sequencia #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .abortar      (abortar),
      .ultimo       (ultimo),
      .ram_dado     (ram_dado),
`ifdef PLAYSEQ_MOSTRA_PAUSA_EN
      .pausar       (pausar),
`endif
      .ram_endereco (ram_endereco),
      .leds         (leds),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] leds;
      logic [3:0] addr;
      logic       oc;
      logic       pr;
      logic [2:0] db;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, " leds"}, 32'(leds), 32'(e.leds));
      chk({tag, " addr"}, 32'(ram_endereco), 32'(e.addr));
      chk({tag, " ocupado"}, 32'(ocupado), 32'(e.oc));
      chk({tag, " pronto"}, 32'(pronto), 32'(e.pr));
      chk({tag, " db"}, 32'(db_estado), 32'(e.db));
   endtask

   function automatic exp_t idle();
      exp_t e;
      e.leds = '0; e.addr = '0; e.oc = 1'b0; e.pr = 1'b0; e.db = 3'd0;
      return e;
   endfunction

   // Expected outputs for every cycle after the start edge: each word is one
   // fetch cycle, ON lit cycles, OFF dark cycles; then one done cycle.
   task automatic build(input int u, input int abort_c, input int ps, input int plen);
      exp_t e;
      q.delete();
      for (int c = 1; c <= (u + 1) * PER; c++) begin
         int w;
         int p;
         w = (c - 1) / PER;
         p = (c - 1) % PER;
         e.addr = 4'(w);
         e.oc   = 1'b1;
         e.pr   = 1'b0;
         if (p == 0) begin
            e.leds = '0; e.db = 3'd1;
         end else if (p <= ON) begin
            e.leds = ram[w]; e.db = 3'd2;
         end else begin
            e.leds = '0; e.db = 3'd3;
         end
         q.push_back(e);
      end
      e.leds = '0; e.addr = 4'(u); e.oc = 1'b1; e.pr = 1'b1; e.db = 3'd4;
      q.push_back(e);
      // A paused cycle simply repeats the observed outputs.
      for (int i = 0; i < plen; i++) q.insert(ps, q[ps-1]);
      if (abort_c > 0) begin
         while (q.size() > abort_c - 1) void'(q.pop_back());
      end
      q.push_back(idle());
      q.push_back(idle());
   endtask

   task automatic run(input int u, input int abort_c, input int ps, input int plen,
                      input bit disturb);
      build(u, abort_c, ps, plen);
      @(negedge clock);
      iniciar = 1'b1;
      ultimo  = 4'(u);
      @(posedge clock);
      for (int c = 1; c <= q.size(); c++) begin
         @(negedge clock);
         chk_all($sformatf("u%0d c%0d", u, c), q[c-1]);
         iniciar = disturb && q[c-1].oc && ($urandom_range(0, 2) == 0);
         if (disturb) ultimo = 4'($urandom);
         abortar = (c + 1 == abort_c);
`ifdef PLAYSEQ_MOSTRA_PAUSA_EN
         pausar = (c >= ps) && (c < ps + plen);
`endif
      end
      iniciar = 1'b0;
      abortar = 1'b0;
`ifdef PLAYSEQ_MOSTRA_PAUSA_EN
      pausar = 1'b0;
`endif
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 4'(1 << (i % 4));

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk_all("reset held", idle());
      reset = 1'b1;
      @(negedge clock);
      chk_all("reset released", idle());

      // Async reset in the middle of ACENDE
      iniciar = 1'b1; ultimo = 4'd3;
      @(negedge clock);
      iniciar = 1'b0;
      @(negedge clock);
      chk("pre-reset leds", 32'(leds), 32'(ram[0]));
      #1 reset = 1'b0;
      #1 chk_all("async reset", idle());
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Abort and start together in OCIOSO: abort wins
      iniciar = 1'b1; abortar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0; abortar = 1'b0;
      chk_all("abort+start", idle());

      // Directed sequences
      run(3, 0, 0, 0, 1'b0);
      run(0, 0, 0, 0, 1'b0);
      run(3, 0, 0, 0, 1'b1);
      run(3, 18, 0, 0, 1'b0);
      run(3, 0, 0, 0, 1'b0);
      run(15, 0, 0, 0, 1'b0);
`ifdef PLAYSEQ_MOSTRA_PAUSA_EN
      run(3, 0, 2, 5, 1'b0);
`endif

      // Randomized sequences
      for (int r = 0; r < 6; r++) begin
         int u;
         int ab;
         for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
         u  = $urandom_range(0, 15);
         ab = ($urandom_range(0, 1) == 1) ? $urandom_range(2, (u + 1) * PER) : 0;
         run(u, ab, 0, 0, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
